// File: rtl/regfile_wb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_pkg
//
// Shared definitions for the register-file write-back slice: data and index
// widths, the write-source selector enum, the sticky error bit positions and
// a one-hot helper used by the busy scoreboard.
//
// Optional feature macro used elsewhere in this slice: WB_BYPASS_EN
// ---------------------------------------------------------------------------
package regfile_wb_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NREGS    = 1 << ADDR_W;
    localparam int LQ_DEPTH = 2;

    typedef logic [ADDR_W-1:0] reg_idx_t;

    // Which producer owns the write port in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LBUF,
        WB_MEM
    } wb_src_t;

    // Bit positions inside err_sticky.
    localparam int ERR_LQ_OVERFLOW   = 0;
    localparam int ERR_SPURIOUS_RESP = 1;

    // Decode a register index into a one-hot register mask.
    function automatic logic [NREGS-1:0] regOneHot(input reg_idx_t idx);
        logic [NREGS-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/wb_tag_fifo.sv
// ---------------------------------------------------------------------------
// wb_tag_fifo
//
// Small synchronous FIFO holding the destination register index of every
// outstanding load, in issue order. The head entry is the destination of the
// next memory response.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset, empties the FIFO
//   push_i      in   enqueue data_i
//   data_i      in   tag to enqueue
//   pop_i       in   dequeue the head (ignored when empty)
//   head_o      out  current head tag (valid when !empty_o)
//   full_o      out  FIFO holds DEPTH entries
//   empty_o     out  FIFO holds no entries
//   overflow_o  out  push attempted while full with no pop; push is dropped
// ---------------------------------------------------------------------------
module wb_tag_fifo
    import regfile_wb_pkg::*;
#(
    parameter int WIDTH = ADDR_W,
    parameter int DEPTH = LQ_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slots_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign head_o     = slots_q[rdPtr_q];
    assign overflow_o = push_i && full_o && !pop_i;

    // When full, a push is still accepted if the head leaves in the same
    // cycle: the write lands in the slot that is being vacated.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Next-state for pointers and occupancy.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (doPop) begin
            rdPtr_d = nextPtr(rdPtr_q);
        end
        if (doPush) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards every queued tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            slots_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//
// Write-side controller for the 8x16 register file and sole driver of its
// write port. Each cycle it picks at most one producer (ALU result, parked
// load, or fresh load response), registers the chosen write onto
// wb_en/wb_rc/wb_data, and keeps a per-register busy scoreboard for decode.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   issue_valid/_is_load/_rd    decode issues an instruction writing issue_rd
//   alu_valid/_rd/_data         single-cycle ALU result, no backpressure
//   mem_valid/_data, mem_ready  load response handshake, in issue order
//   wb_en/wb_rc/wb_data         register file write port (registered)
//   busy_mask                   bit i set while a write to ri is pending
//   lq_full                     load tag FIFO full, decode must hold loads
//   lbuf_busy                   a load response is parked for the write port
//   err_sticky                  [0] load issued while full,
//                               [1] response with no outstanding load
//
// Optional feature (macro WB_BYPASS_EN): byp_ra/byp_rb inputs and
// byp_hit_a/b, byp_data_a/b outputs forwarding the value being committed.
// ---------------------------------------------------------------------------
module regfile_writeback
    import regfile_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_is_load,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_rc,
    output logic [DATA_W-1:0] wb_data,
    output logic [NREGS-1:0]  busy_mask,
    output logic              lq_full,
    output logic              lbuf_busy,
    output logic [1:0]        err_sticky
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] byp_ra,
    input  logic [ADDR_W-1:0] byp_rb,
    output logic              byp_hit_a,
    output logic              byp_hit_b,
    output logic [DATA_W-1:0] byp_data_a,
    output logic [DATA_W-1:0] byp_data_b
`endif
);

    wb_src_t           wbSrc;
    logic              wbEn_q, wbEn_d;
    logic [ADDR_W-1:0] wbRc_q, wbRc_d;
    logic [DATA_W-1:0] wbData_q, wbData_d;
    logic              lbufValid_q, lbufValid_d;
    logic [ADDR_W-1:0] lbufRc_q, lbufRc_d;
    logic [DATA_W-1:0] lbufData_q, lbufData_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [1:0]        errSticky_q, errSticky_d;

    logic              memAccept;
    logic              respValid;
    logic              spuriousResp;
    logic              tagPush;
    logic [ADDR_W-1:0] tagHead;
    logic              tagFull;
    logic              tagEmpty;
    logic              tagOverflow;

    // Outstanding load destinations, oldest first.
    wb_tag_fifo #(
        .WIDTH(ADDR_W),
        .DEPTH(LQ_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (tagPush),
        .data_i    (issue_rd),
        .pop_i     (respValid),
        .head_o    (tagHead),
        .full_o    (tagFull),
        .empty_o   (tagEmpty),
        .overflow_o(tagOverflow)
    );

    // A response is only refused while the park buffer is occupied; the park
    // buffer is the single place a response can wait for the write port.
    assign mem_ready    = !lbufValid_q;
    assign memAccept    = mem_valid && mem_ready;
    assign respValid    = memAccept && !tagEmpty;
    assign spuriousResp = memAccept && tagEmpty;
    assign tagPush      = issue_valid && issue_is_load;

    assign wb_en      = wbEn_q;
    assign wb_rc      = wbRc_q;
    assign wb_data    = wbData_q;
    assign busy_mask  = busy_q;
    assign lq_full    = tagFull;
    assign lbuf_busy  = lbufValid_q;
    assign err_sticky = errSticky_q;

    // Write-port arbitration. The ALU has no backpressure so it always wins;
    // a response arriving alongside it is parked with its popped tag. A
    // parked response goes next, and a fresh response is written directly
    // only when nothing else wants the port. With no source the port data
    // holds its last value and only the enable drops.
    always_comb begin
        wbSrc       = WB_NONE;
        lbufValid_d = lbufValid_q;
        lbufRc_d    = lbufRc_q;
        lbufData_d  = lbufData_q;
        wbEn_d      = 1'b0;
        wbRc_d      = wbRc_q;
        wbData_d    = wbData_q;

        if (alu_valid) begin
            wbSrc = WB_ALU;
            if (respValid) begin
                lbufValid_d = 1'b1;
                lbufRc_d    = tagHead;
                lbufData_d  = mem_data;
            end
        end else if (lbufValid_q) begin
            wbSrc       = WB_LBUF;
            lbufValid_d = 1'b0;
        end else if (respValid) begin
            wbSrc = WB_MEM;
        end

        case (wbSrc)
            WB_ALU: begin
                wbEn_d   = 1'b1;
                wbRc_d   = alu_rd;
                wbData_d = alu_data;
            end
            WB_LBUF: begin
                wbEn_d   = 1'b1;
                wbRc_d   = lbufRc_q;
                wbData_d = lbufData_q;
            end
            WB_MEM: begin
                wbEn_d   = 1'b1;
                wbRc_d   = tagHead;
                wbData_d = mem_data;
            end
            WB_NONE: begin
                wbEn_d = 1'b0;
            end
            default: begin
                wbEn_d = 1'b0;
            end
        endcase
    end

    // Busy scoreboard and sticky errors. The clear uses the write currently
    // on the port (it commits at this edge); the set is applied afterwards so
    // a re-issue of the register being committed stays pending.
    always_comb begin
        busy_d = busy_q;
        if (wbEn_q) begin
            busy_d = busy_d & ~regOneHot(wbRc_q);
        end
        if (issue_valid) begin
            busy_d = busy_d | regOneHot(issue_rd);
        end

        errSticky_d = errSticky_q;
        if (tagOverflow) begin
            errSticky_d[ERR_LQ_OVERFLOW] = 1'b1;
        end
        if (spuriousResp) begin
            errSticky_d[ERR_SPURIOUS_RESP] = 1'b1;
        end
    end

    // All controller state; reset drops any parked response along with the
    // queued tags in the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbEn_q      <= 1'b0;
            wbRc_q      <= '0;
            wbData_q    <= '0;
            lbufValid_q <= 1'b0;
            lbufRc_q    <= '0;
            lbufData_q  <= '0;
            busy_q      <= '0;
            errSticky_q <= '0;
        end else begin
            wbEn_q      <= wbEn_d;
            wbRc_q      <= wbRc_d;
            wbData_q    <= wbData_d;
            lbufValid_q <= lbufValid_d;
            lbufRc_q    <= lbufRc_d;
            lbufData_q  <= lbufData_d;
            busy_q      <= busy_d;
            errSticky_q <= errSticky_d;
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the value the register file is committing this cycle, so
    // decode does not read the stale copy.
    assign byp_hit_a  = wbEn_q && (wbRc_q == byp_ra);
    assign byp_hit_b  = wbEn_q && (wbRc_q == byp_rb);
    assign byp_data_a = wbData_q;
    assign byp_data_b = wbData_q;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback
//
// Directed bench for regfile_writeback. Stimulus pushes each expected
// register write into a queue; a separate monitor pops and compares whenever
// the write port is enabled. Status outputs are compared directly from the
// stimulus thread, one step after the clock edge.
// ---------------------------------------------------------------------------
module tb_regfile_writeback;
    import regfile_wb_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_valid;
    logic              issue_is_load;
    logic [ADDR_W-1:0] issue_rd;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_rc;
    logic [DATA_W-1:0] wb_data;
    logic [NREGS-1:0]  busy_mask;
    logic              lq_full;
    logic              lbuf_busy;
    logic [1:0]        err_sticky;
`ifdef WB_BYPASS_EN
    logic [ADDR_W-1:0] byp_ra;
    logic [ADDR_W-1:0] byp_rb;
    logic              byp_hit_a;
    logic              byp_hit_b;
    logic [DATA_W-1:0] byp_data_a;
    logic [DATA_W-1:0] byp_data_b;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] rc;
        logic [DATA_W-1:0] data;
    } wbExp_t;

    wbExp_t expQ[$];
    int     checks = 0;
    int     errors = 0;

    regfile_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_is_load(issue_is_load),
        .issue_rd     (issue_rd),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .wb_en        (wb_en),
        .wb_rc        (wb_rc),
        .wb_data      (wb_data),
        .busy_mask    (busy_mask),
        .lq_full      (lq_full),
        .lbuf_busy    (lbuf_busy),
        .err_sticky   (err_sticky)
`ifdef WB_BYPASS_EN
        ,
        .byp_ra       (byp_ra),
        .byp_rb       (byp_rb),
        .byp_hit_a    (byp_hit_a),
        .byp_hit_b    (byp_hit_b),
        .byp_data_a   (byp_data_a),
        .byp_data_b   (byp_data_b)
`endif
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // One comparison: counts it, reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the DUT sample them, return 1 after edge.
    task automatic applyStimulus(input logic iv, input logic il, input logic [ADDR_W-1:0] ird,
                                 input logic av, input logic [ADDR_W-1:0] ard,
                                 input logic [DATA_W-1:0] adat,
                                 input logic mv, input logic [DATA_W-1:0] mdat);
        issue_valid   = iv;
        issue_is_load = il;
        issue_rd      = ird;
        alu_valid     = av;
        alu_rd        = ard;
        alu_data      = adat;
        mem_valid     = mv;
        mem_data      = mdat;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic expectWrite(input logic [ADDR_W-1:0] rc, input logic [DATA_W-1:0] data);
        wbExp_t e;
        e.rc   = rc;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Monitor: every enabled write must match the oldest expected write.
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got r%0d=0x%0h, expected no write",
                         wb_rc, wb_data);
            end else begin
                wbExp_t e;
                e = expQ.pop_front();
                checkOutput("wb_rc", 32'(wb_rc), 32'(e.rc));
                checkOutput("wb_data", 32'(wb_data), 32'(e.data));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
`ifdef WB_BYPASS_EN
        byp_ra = '0;
        byp_rb = '0;
`endif

        // Reset held two cycles with an ALU result pending.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd7, 16'hFFFF, 1'b0, 16'h0);
            checkOutput("reset_wb_en", 32'(wb_en), 32'h0);
            checkOutput("reset_busy", 32'(busy_mask), 32'h0);
            checkOutput("reset_err", 32'(err_sticky), 32'h0);
            checkOutput("reset_lq_full", 32'(lq_full), 32'h0);
        end
        rst_n = 1'b1;
        expectWrite(3'd7, 16'hFFFF);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd7, 16'hFFFF, 1'b0, 16'h0);
        checkOutput("release_wb_en", 32'(wb_en), 32'h1);
        idleCycle();

        // ALU only: issue r3, then write it.
        applyStimulus(1'b1, 1'b0, 3'd3, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        checkOutput("alu_busy_set", 32'(busy_mask), 32'h08);
        expectWrite(3'd3, 16'h1234);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 16'h1234, 1'b0, 16'h0);
        checkOutput("alu_busy_during_commit", 32'(busy_mask), 32'h08);
        idleCycle();
        checkOutput("alu_busy_cleared", 32'(busy_mask), 32'h00);

        // Conflict: ALU and load response in the same cycle.
        applyStimulus(1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        checkOutput("conf_busy_set", 32'(busy_mask), 32'h20);
        checkOutput("conf_lq_full", 32'(lq_full), 32'h0);
        expectWrite(3'd2, 16'h0001);
        expectWrite(3'd5, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 16'h0001, 1'b1, 16'hBEEF);
        checkOutput("conf_lbuf_busy", 32'(lbuf_busy), 32'h1);
        checkOutput("conf_mem_ready", 32'(mem_ready), 32'h0);
        idleCycle();
        checkOutput("conf_lbuf_drained", 32'(lbuf_busy), 32'h0);
        checkOutput("conf_mem_ready_back", 32'(mem_ready), 32'h1);
        idleCycle();
        checkOutput("conf_busy_cleared", 32'(busy_mask), 32'h00);

        // Ordering and full tag FIFO.
        applyStimulus(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b1, 3'd6, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        checkOutput("full_lq_full", 32'(lq_full), 32'h1);
        checkOutput("full_busy", 32'(busy_mask), 32'h42);
        checkOutput("full_err_clean", 32'(err_sticky), 32'h0);
        applyStimulus(1'b1, 1'b1, 3'd6, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        checkOutput("full_overflow_err", 32'(err_sticky), 32'h1);
        checkOutput("full_still_full", 32'(lq_full), 32'h1);
        // Push r4 while full, together with the pop of r1.
        expectWrite(3'd1, 16'hAAAA);
        applyStimulus(1'b1, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0, 1'b1, 16'hAAAA);
        checkOutput("pushpop_full", 32'(lq_full), 32'h1);
        checkOutput("pushpop_err", 32'(err_sticky), 32'h1);
        checkOutput("pushpop_busy", 32'(busy_mask), 32'h52);
        expectWrite(3'd6, 16'hBBBB);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 16'hBBBB);
        expectWrite(3'd4, 16'hDDDD);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 16'hDDDD);
        checkOutput("drain_lq_empty", 32'(lq_full), 32'h0);
        idleCycle();
        checkOutput("drain_busy", 32'(busy_mask), 32'h00);
        checkOutput("drain_err", 32'(err_sticky), 32'h1);

        // Spurious response: no load outstanding.
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h5555);
        checkOutput("spur_err", 32'(err_sticky), 32'h3);
        checkOutput("spur_no_write", 32'(wb_en), 32'h0);
        idleCycle();
        idleCycle();
        checkOutput("spur_err_sticky", 32'(err_sticky), 32'h3);

        // Scoreboard race: r4 re-issued while its write commits.
        applyStimulus(1'b1, 1'b0, 3'd4, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        checkOutput("race_busy_set", 32'(busy_mask), 32'h10);
        expectWrite(3'd4, 16'h4444);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1, 3'd4, 16'h4444, 1'b0, 16'h0);
`ifdef WB_BYPASS_EN
        byp_ra = 3'd4;
        byp_rb = 3'd3;
        #1;
        checkOutput("byp_hit_a", 32'(byp_hit_a), 32'h1);
        checkOutput("byp_data_a", 32'(byp_data_a), 32'h4444);
        checkOutput("byp_hit_b", 32'(byp_hit_b), 32'h0);
`endif
        applyStimulus(1'b1, 1'b0, 3'd4, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        checkOutput("race_set_wins", 32'(busy_mask), 32'h10);
`ifdef WB_BYPASS_EN
        checkOutput("byp_idle_miss", 32'(byp_hit_a), 32'h0);
`endif

        // Reset mid-operation discards the outstanding load tag.
        applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0);
        rst_n = 1'b0;
        idleCycle();
        checkOutput("midrst_busy", 32'(busy_mask), 32'h0);
        checkOutput("midrst_err", 32'(err_sticky), 32'h0);
        checkOutput("midrst_wb_en", 32'(wb_en), 32'h0);
        checkOutput("midrst_lbuf", 32'(lbuf_busy), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 16'h7777);
        checkOutput("midrst_tag_gone", 32'(err_sticky), 32'h2);
        idleCycle();

        // Every expected write must have appeared within a bounded wait.
        for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
            @(posedge clk);
        end
        checkOutput("pending_writes", 32'(expQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side controller for the 8x16 register file; sole driver of its write port (write_enable, rc, write_data).
- Merges single-cycle ALU results with multi-cycle memory load responses into at most one register write per cycle.
- Keeps a per-register busy scoreboard so decode can stall on pending destinations.
- Sits between execute/memory stages and the register file.

Parameters:
DATA_W, 16, register data width
ADDR_W, 3, register index width
NREGS, 8, number of architectural registers (2**ADDR_W)
LQ_DEPTH, 2, outstanding-load tag FIFO depth

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
issue_valid  in  1  decode issues an instruction that writes issue_rd
issue_is_load  in  1  issued instruction is a load
issue_rd  in  ADDR_W  destination register of issued instruction
alu_valid  in  1  ALU result valid this cycle (no backpressure)
alu_rd  in  ADDR_W  ALU destination
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load response valid
mem_data  in  DATA_W  load response data
mem_ready  out  1  load response accepted when mem_valid&&mem_ready
wb_en  out  1  register file write_enable
wb_rc  out  ADDR_W  register file rc
wb_data  out  DATA_W  register file write_data
busy_mask  out  NREGS  bit i=1: write to ri pending
lq_full  out  1  load tag FIFO full; decode must not issue loads
lbuf_busy  out  1  parked load waiting for the write port
err_sticky  out  2  [0] load issued while lq_full, [1] mem response with empty tag FIFO

Behaviour:
- Reset (rst_n=0 at posedge): wb_en=0, wb_rc=0, wb_data=0, busy_mask=0, tag FIFO empty, lbuf empty, err_sticky=0, lq_full=0. Reset mid-operation discards all pending loads/tags.
- wb_en/wb_rc/wb_data are registered: a source selected in cycle N drives the port in cycle N+1; the register file commits at the end of N+1.
- Load tags: issue_valid&&issue_is_load pushes issue_rd into the tag FIFO. An accepted mem response pops the head; that head is the response's destination. Responses return in issue order.
- mem_ready = !lbuf_valid (combinational).
- Source priority in cycle N, evaluated in order:
  1. alu_valid: write ALU. A response accepted the same cycle is parked in lbuf with its popped tag.
  2. else lbuf_valid: write lbuf; lbuf clears.
  3. else accepted mem response: write it directly.
  4. else wb_en=0 next cycle; wb_rc/wb_data hold their values.
- ALU always wins. Avoiding load starvation is decode's job (throttle ALU ops while lbuf_busy=1).
- Scoreboard: issue_valid sets busy_mask[issue_rd]; wb_en clears busy_mask[wb_rc] at the commit edge. Same register set and cleared in one cycle: set wins.
- Tag FIFO boundaries:
  - Push and pop in the same cycle is legal when full.
  - Push while full with no pop: push dropped, err_sticky[0] set.
  - mem_valid with FIFO empty and lbuf empty: response accepted and dropped, no write, err_sticky[1] set.
- err_sticky bits clear only on reset.
- r0 is an ordinary writable register.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: adds inputs byp_ra, byp_rb (ADDR_W) and outputs byp_hit_a, byp_hit_b (1), byp_data_a, byp_data_b (DATA_W).
  - byp_hit_x = wb_en && (wb_rc == byp_rx), combinational.
  - byp_data_x = wb_data.
  - Lets decode forward the value being committed this cycle.
- Undefined: these ports do not exist; no other behaviour changes.

Decomposition:
- Package regfile_wb_pkg holds:
  - DATA_W, ADDR_W, NREGS constants
  - typedef reg_idx_t
  - enum wb_src_t {WB_NONE, WB_ALU, WB_LBUF, WB_MEM}
  - error bit index constants
- One sub-module: wb_tag_fifo, a synchronous FIFO of ADDR_W tags, LQ_DEPTH deep, with full/empty and simultaneous push/pop.

Test Plan:
- Reset: hold rst_n=0 two cycles with alu_valid=1 -> wb_en=0, busy_mask=0, err_sticky=0 throughout; first write appears only after release.
- ALU only: issue r3, alu_valid rd=3 data=0x1234 in cycle N -> wb_en=1, wb_rc=3, wb_data=0x1234 in N+1; busy_mask[3] 1 then 0 after N+1.
- Conflict: load to r5 outstanding; mem_valid data=0xBEEF with alu_valid rd=2 data=0x0001 -> r2 written N+1, lbuf_busy=1, mem_ready=0; r5=0xBEEF written N+2.
- Ordering/full: issue loads to r1 then r6 (LQ_DEPTH=2) -> lq_full=1; third load push sets err_sticky[0]; responses 0xAAAA, 0xBBBB -> r1=0xAAAA, r6=0xBBBB.
- Spurious response: mem_valid with no outstanding load -> no write, err_sticky[1]=1 and stays set.
- Scoreboard race: wb commits r4 while issue_rd=4 in the same cycle -> busy_mask[4]=1 afterward; with WB_BYPASS_EN, byp_ra=4 during the commit cycle -> byp_hit_a=1, byp_data_a=wb_data.
